// File: rtl/qracc_pkg.sv
// Shared QR-ACC types: the SRAM port protocol plus the arbiter's payload and state types.
package qracc_pkg;

    localparam int numRows    = 128;
    localparam int numCols    = 32;
    localparam int addrBits   = $clog2(numRows);
    localparam int arbNumReq  = 2;
    localparam int arbIdBits  = $clog2(arbNumReq);

    typedef struct packed {
        logic                rq_valid_i;
        logic                rq_wr_i;
        logic [addrBits-1:0] rq_addr_i;
        logic [numCols-1:0]  rq_wr_data_i;
    } to_sram_t;

    typedef struct packed {
        logic               rq_ready_o;
        logic               rd_valid_o;
        logic [numCols-1:0] rd_data_o;
    } from_sram_t;

    typedef struct packed {
        logic                wr;
        logic [addrBits-1:0] addr;
        logic [numCols-1:0]  wr_data;
    } sram_req_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/qracc_id_fifo.sv
// Small synchronous FIFO holding requester IDs of reads still awaiting SRAM data.
module qracc_id_fifo #(
    parameter int width = 1,
    parameter int depth = 4,
    localparam int ptrBits = $clog2(depth)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [width-1:0]   push_data,
    input  logic               pop,
    output logic [width-1:0]   pop_data,
    output logic               full,
    output logic               empty,
    output logic [ptrBits:0]   count
);

    logic [width-1:0]   mem [depth];
    logic [ptrBits-1:0] wr_ptr;
    logic [ptrBits-1:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full     = (count == (ptrBits + 1)'(depth));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO is still safe.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/qracc_sram_arbiter.sv
// Round-robin arbiter sharing one SRAM request port between several requesters,
// routing each read return back to the requester that issued it.
module qracc_sram_arbiter
    import qracc_pkg::*;
#(
    parameter int numReq         = 2,
    parameter int maxOutstanding = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [numReq-1:0]          req_valid_i,
    input  logic [numReq-1:0]          req_wr_i,
    input  logic [numReq*addrBits-1:0] req_addr_i,
    input  logic [numReq*numCols-1:0]  req_wr_data_i,
    output logic [numReq-1:0]          req_ready_o,
    output logic [numReq-1:0]          req_rd_valid_o,
    output logic [numCols-1:0]         req_rd_data_o,
    output to_sram_t                   sram_o,
    input  from_sram_t                 sram_i,
    output logic                       busy_o
);

    localparam int idBits  = $clog2(numReq);
    localparam int cntBits = $clog2(maxOutstanding) + 1;

    // Handshake: a request transfers on the cycle its valid and ready are both high;
    // valid and payload must then stay stable until that cycle.

    arb_state_e          state_q, state_d;
    logic [idBits-1:0]   gnt_q, gnt_d;
    logic [idBits-1:0]   last_q, last_d;
    logic                stale_rd_q;

    sram_req_t           req_pl [numReq];
    logic [numReq-1:0]   eligible;
    logic                pick_found;
    logic [idBits-1:0]   pick_idx;
    logic                sel_valid;
    logic [idBits-1:0]   sel_idx;
    logic                hs;

    logic                fifo_push;
    logic                fifo_pop;
    logic [idBits-1:0]   fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [cntBits-1:0]  fifo_count;

    always_comb begin
        for (int k = 0; k < numReq; k++) begin
            req_pl[k].wr      = req_wr_i[k];
            req_pl[k].addr    = req_addr_i[k*addrBits +: addrBits];
            req_pl[k].wr_data = req_wr_data_i[k*numCols +: numCols];
        end
    end

    // Reads cannot be accepted once every return slot is taken; writes need none.
    assign eligible = req_valid_i & (req_wr_i | {numReq{~fifo_full}});

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= numReq; i++) begin
            if (!pick_found && eligible[(int'(last_q) + i) % numReq]) begin
                pick_found = 1'b1;
                pick_idx   = idBits'((int'(last_q) + i) % numReq);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            last_q  <= idBits'(numReq - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    if (hs) begin
                        last_d = pick_idx;
                    end else begin
                        state_d = ARB_LOCKED;
                        gnt_d   = pick_idx;
                    end
                end
            end
            ARB_LOCKED: begin
                if (hs) begin
                    state_d = ARB_IDLE;
                    last_d  = gnt_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        case (state_q)
            ARB_IDLE: begin
                sel_valid = pick_found;
                sel_idx   = pick_found ? pick_idx : '0;
            end
            ARB_LOCKED: begin
                sel_valid = req_valid_i[gnt_q];
                sel_idx   = gnt_q;
            end
            default: begin
                sel_valid = 1'b0;
                sel_idx   = '0;
            end
        endcase
        if (rst) sel_valid = 1'b0;

        hs = sel_valid & sram_i.rq_ready_o;

        sram_o.rq_valid_i   = sel_valid;
        sram_o.rq_wr_i      = req_pl[sel_idx].wr;
        sram_o.rq_addr_i    = req_pl[sel_idx].addr;
        sram_o.rq_wr_data_i = req_pl[sel_idx].wr_data;

        req_ready_o = '0;
        if (hs) req_ready_o[sel_idx] = 1'b1;

        req_rd_valid_o = '0;
        if (fifo_pop) req_rd_valid_o[fifo_head] = 1'b1;
    end

    assign fifo_push     = hs & ~req_pl[sel_idx].wr;
    assign fifo_pop      = sram_i.rd_valid_o & ~fifo_empty & ~rst;
    assign req_rd_data_o = sram_i.rd_data_o;
    assign busy_o        = (state_q == ARB_LOCKED) | (fifo_count != '0);

    qracc_id_fifo #(
        .width (idBits),
        .depth (maxOutstanding)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (sel_idx),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Reads issued before a reset may still come back; they are legal until a new read is issued.
    always_ff @(posedge clk) begin
        if (rst)            stale_rd_q <= 1'b1;
        else if (fifo_push) stale_rd_q <= 1'b0;
    end

    a_hold_valid : assert property (@(posedge clk) disable iff (rst)
        (state_q == ARB_LOCKED) |-> req_valid_i[gnt_q]);

    a_no_orphan_return : assert property (@(posedge clk) disable iff (rst)
        (sram_i.rd_valid_o && fifo_empty) |-> stale_rd_q);

endmodule

// File: tb/tb_qracc_sram_arbiter.sv
// Directed vector bench for qracc_sram_arbiter: one record per cycle of inputs and expected outputs.
module tb_qracc_sram_arbiter;
    import qracc_pkg::*;

    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic [1:0]  w;
        logic [6:0]  a0;
        logic [6:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        rdy;
        logic        rv;
        logic [31:0] rdat;
        logic [1:0]  e_rr;
        logic [1:0]  e_rv;
        logic        e_sv;
        logic        e_sw;
        logic [6:0]  e_sa;
        logic [31:0] e_sd;
        logic        e_busy;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_wr_i;
    logic [13:0] req_addr_i;
    logic [63:0] req_wr_data_i;
    logic [1:0]  req_ready_o;
    logic [1:0]  req_rd_valid_o;
    logic [31:0] req_rd_data_o;
    to_sram_t    sram_o;
    from_sram_t  sram_i;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    qracc_sram_arbiter #(
        .numReq         (2),
        .maxOutstanding (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_wr_i       (req_wr_i),
        .req_addr_i     (req_addr_i),
        .req_wr_data_i  (req_wr_data_i),
        .req_ready_o    (req_ready_o),
        .req_rd_valid_o (req_rd_valid_o),
        .req_rd_data_o  (req_rd_data_o),
        .sram_o         (sram_o),
        .sram_i         (sram_i),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [1:0] w,
                                input logic [6:0] a0, input logic [6:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic rdy, input logic rv, input logic [31:0] rdat,
                                input logic [1:0] e_rr, input logic [1:0] e_rv,
                                input logic e_sv, input logic e_sw, input logic [6:0] e_sa,
                                input logic [31:0] e_sd, input logic e_busy);
        vec_t t;
        t.rst = r;    t.v = v;       t.w = w;       t.a0 = a0;     t.a1 = a1;
        t.d0 = d0;    t.d1 = d1;     t.rdy = rdy;   t.rv = rv;     t.rdat = rdat;
        t.e_rr = e_rr; t.e_rv = e_rv; t.e_sv = e_sv; t.e_sw = e_sw; t.e_sa = e_sa;
        t.e_sd = e_sd; t.e_busy = e_busy;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t t);
        @(negedge clk);
        rst           = t.rst;
        req_valid_i   = t.v;
        req_wr_i      = t.w;
        req_addr_i    = {t.a1, t.a0};
        req_wr_data_i = {t.d1, t.d0};
        sram_i.rq_ready_o = t.rdy;
        sram_i.rd_valid_o = t.rv;
        sram_i.rd_data_o  = t.rdat;
        #1;
        chk({tag, ".ready"},    32'(req_ready_o),    32'(t.e_rr));
        chk({tag, ".rd_valid"}, 32'(req_rd_valid_o), 32'(t.e_rv));
        chk({tag, ".sram_vld"}, 32'(sram_o.rq_valid_i), 32'(t.e_sv));
        chk({tag, ".busy"},     32'(busy_o),         32'(t.e_busy));
        if (t.e_sv) begin
            chk({tag, ".sram_wr"},   32'(sram_o.rq_wr_i),   32'(t.e_sw));
            chk({tag, ".sram_addr"}, 32'(sram_o.rq_addr_i), 32'(t.e_sa));
            chk({tag, ".sram_data"}, sram_o.rq_wr_data_i,   t.e_sd);
        end
        if (t.e_rv != 2'b00) begin
            chk({tag, ".rd_data"}, req_rd_data_o, t.rdat);
        end
    endtask

    initial begin
        // Single write from requester 1, then fairness under full contention.
        vecs.push_back(mk(0, 2'b10, 2'b10, 7'd0, 7'd5, 32'h0, 32'hDEADBEEF, 1, 0, 32'h0,
                          2'b10, 2'b00, 1, 1, 7'd5, 32'hDEADBEEF, 0));
        for (int k = 0; k < 6; k++) begin
            vecs.push_back(mk(0, 2'b11, 2'b11, 7'd10, 7'd20, 32'hA0, 32'hB1, 1, 0, 32'h0,
                              (k % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 1, 1,
                              (k % 2 == 0) ? 7'd10 : 7'd20,
                              (k % 2 == 0) ? 32'hA0 : 32'hB1, 0));
        end
        // Requester 0 locked through three stalled cycles while requester 1 waits.
        vecs.push_back(mk(0, 2'b01, 2'b01, 7'd30, 7'd0, 32'hC0, 32'h0, 0, 0, 32'h0,
                          2'b00, 2'b00, 1, 1, 7'd30, 32'hC0, 0));
        for (int k = 0; k < 2; k++) begin
            vecs.push_back(mk(0, 2'b11, 2'b11, 7'd30, 7'd40, 32'hC0, 32'hD1, 0, 0, 32'h0,
                              2'b00, 2'b00, 1, 1, 7'd30, 32'hC0, 1));
        end
        vecs.push_back(mk(0, 2'b11, 2'b11, 7'd30, 7'd40, 32'hC0, 32'hD1, 1, 0, 32'h0,
                          2'b01, 2'b00, 1, 1, 7'd30, 32'hC0, 1));
        vecs.push_back(mk(0, 2'b10, 2'b11, 7'd30, 7'd40, 32'hC0, 32'hD1, 1, 0, 32'h0,
                          2'b10, 2'b00, 1, 1, 7'd40, 32'hD1, 0));
        // Reads 0/1/0 with returns two cycles after issue.
        vecs.push_back(mk(0, 2'b01, 2'b00, 7'd1, 7'd0, 32'h0, 32'h0, 1, 0, 32'h0,
                          2'b01, 2'b00, 1, 0, 7'd1, 32'h0, 0));
        vecs.push_back(mk(0, 2'b10, 2'b00, 7'd0, 7'd2, 32'h0, 32'h0, 1, 0, 32'h0,
                          2'b10, 2'b00, 1, 0, 7'd2, 32'h0, 1));
        vecs.push_back(mk(0, 2'b01, 2'b00, 7'd3, 7'd0, 32'h0, 32'h0, 1, 1, 32'h1111,
                          2'b01, 2'b01, 1, 0, 7'd3, 32'h0, 1));
        vecs.push_back(mk(0, 2'b00, 2'b00, 7'd0, 7'd0, 32'h0, 32'h0, 1, 1, 32'h2222,
                          2'b00, 2'b10, 0, 0, 7'd0, 32'h0, 1));
        vecs.push_back(mk(0, 2'b00, 2'b00, 7'd0, 7'd0, 32'h0, 32'h0, 1, 1, 32'h3333,
                          2'b00, 2'b01, 0, 0, 7'd0, 32'h0, 1));
        vecs.push_back(mk(0, 2'b00, 2'b00, 7'd0, 7'd0, 32'h0, 32'h0, 1, 0, 32'h0,
                          2'b00, 2'b00, 0, 0, 7'd0, 32'h0, 0));
        // Fill the return FIFO, then a blocked read beside a still-granted write.
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(mk(0, 2'b01, 2'b00, 7'(8 + k), 7'd0, 32'h0, 32'h0, 1, 0, 32'h0,
                              2'b01, 2'b00, 1, 0, 7'(8 + k), 32'h0, (k == 0) ? 1'b0 : 1'b1));
        end
        vecs.push_back(mk(0, 2'b10, 2'b00, 7'd0, 7'd12, 32'h0, 32'h0, 1, 0, 32'h0,
                          2'b00, 2'b00, 0, 0, 7'd0, 32'h0, 1));
        vecs.push_back(mk(0, 2'b11, 2'b01, 7'd13, 7'd12, 32'hE0, 32'h0, 1, 0, 32'h0,
                          2'b01, 2'b00, 1, 1, 7'd13, 32'hE0, 1));
        vecs.push_back(mk(0, 2'b10, 2'b00, 7'd0, 7'd12, 32'h0, 32'h0, 1, 1, 32'h4444,
                          2'b00, 2'b01, 0, 0, 7'd0, 32'h0, 1));
        vecs.push_back(mk(0, 2'b10, 2'b00, 7'd0, 7'd12, 32'h0, 32'h0, 1, 0, 32'h0,
                          2'b10, 2'b00, 1, 0, 7'd12, 32'h0, 1));
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(mk(0, 2'b00, 2'b00, 7'd0, 7'd0, 32'h0, 32'h0, 1, 1, 32'(32'h5550 + k),
                              2'b00, (k == 3) ? 2'b10 : 2'b01, 0, 0, 7'd0, 32'h0, 1));
        end
        vecs.push_back(mk(0, 2'b00, 2'b00, 7'd0, 7'd0, 32'h0, 32'h0, 1, 0, 32'h0,
                          2'b00, 2'b00, 0, 0, 7'd0, 32'h0, 0));

        rst = 1'b1;
        req_valid_i   = 2'b11;
        req_wr_i      = 2'b00;
        req_addr_i    = '0;
        req_wr_data_i = '0;
        sram_i.rq_ready_o = 1'b1;
        sram_i.rd_valid_o = 1'b1;
        sram_i.rd_data_o  = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset.ready",    32'(req_ready_o),       32'h0);
        chk("reset.rd_valid", 32'(req_rd_valid_o),    32'h0);
        chk("reset.sram_vld", 32'(sram_o.rq_valid_i), 32'h0);
        chk("reset.busy",     32'(busy_o),            32'h0);

        foreach (vecs[i]) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Reset while locked with two reads outstanding; late returns must be dropped.
        run_vec("r1", mk(0, 2'b01, 2'b00, 7'd20, 7'd0, 32'h0, 32'h0, 1, 0, 32'h0,
                         2'b01, 2'b00, 1, 0, 7'd20, 32'h0, 0));
        run_vec("r2", mk(0, 2'b10, 2'b00, 7'd0, 7'd21, 32'h0, 32'h0, 1, 0, 32'h0,
                         2'b10, 2'b00, 1, 0, 7'd21, 32'h0, 1));
        run_vec("r3", mk(0, 2'b01, 2'b01, 7'd22, 7'd0, 32'hF0, 32'h0, 0, 0, 32'h0,
                         2'b00, 2'b00, 1, 1, 7'd22, 32'hF0, 1));
        run_vec("r4", mk(1, 2'b01, 2'b01, 7'd22, 7'd0, 32'hF0, 32'h0, 0, 0, 32'h0,
                         2'b00, 2'b00, 0, 0, 7'd0, 32'h0, 1));
        run_vec("r5", mk(0, 2'b00, 2'b00, 7'd0, 7'd0, 32'h0, 32'h0, 1, 1, 32'h7777,
                         2'b00, 2'b00, 0, 0, 7'd0, 32'h0, 0));
        run_vec("r6", mk(0, 2'b00, 2'b00, 7'd0, 7'd0, 32'h0, 32'h0, 1, 1, 32'h8888,
                         2'b00, 2'b00, 0, 0, 7'd0, 32'h0, 0));
        run_vec("r7", mk(0, 2'b11, 2'b11, 7'd23, 7'd24, 32'h1, 32'h2, 1, 0, 32'h0,
                         2'b01, 2'b00, 1, 1, 7'd23, 32'h1, 0));
        run_vec("r8", mk(0, 2'b11, 2'b11, 7'd23, 7'd24, 32'h1, 32'h2, 1, 0, 32'h0,
                         2'b10, 2'b00, 1, 1, 7'd24, 32'h2, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qracc_sram_arbiter.md
# qracc_sram_arbiter

Round-robin arbiter that shares one SRAM request port (the `to_sram_t`/`from_sram_t` protocol) between `numReq` requesters, e.g. the weight loader and the debug/readback path. It sits between the requesters and the SRAM/analog-column wrapper. It muxes requests onto the single port and holds the grant stable across back-pressure. It tracks outstanding reads so that each `rd_valid_o` and its `rd_data_o` return to the requester that issued the read.

## Interface
- `numRows`, 128, SRAM rows; address width is `$clog2(numRows)`.
- `numCols`, 32, SRAM data width.
- `numReq`, 2, number of requesters, ≥2.
- `maxOutstanding`, 4, depth of the read-return ID FIFO; must be a power of 2.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid_i` in `numReq`: per-requester request valid.
- `req_wr_i` in `numReq`: 1 = write, 0 = read.
- `req_addr_i` in `numReq*$clog2(numRows)`: packed addresses, requester 0 in the LSBs.
- `req_wr_data_i` in `numReq*numCols`: packed write data.
- `req_ready_o` out `numReq`: request accepted when both valid and ready are high.
- `req_rd_valid_o` out `numReq`: one-hot read return.
- `req_rd_data_o` out `numCols`: broadcast read data; qualify with `req_rd_valid_o`.
- `sram_o` out `to_sram_t`: request to the SRAM.
- `sram_i` in `from_sram_t`: SRAM response.
- `busy_o` out 1: a grant is held or reads are outstanding.

## Operation
- Grant register `gnt_q` (index) plus `lock_q`. FSM states:
  - IDLE (`lock_q=0`)
  - LOCKED (`lock_q=1`)
- IDLE:
  - Round-robin pick among eligible `req_valid_i`. Search starts at `last_q+1` and wraps modulo `numReq`.
  - Eligibility: a read request is ineligible while the ID FIFO is full. Writes are always eligible.
  - The picked request drives `sram_o` combinationally in the same cycle.
  - On `sram_i.rq_ready_o` = 1: the handshake completes and the FSM stays in IDLE; `last_q` ← winner.
  - Otherwise: LOCKED with `gnt_q` ← winner.
- LOCKED:
  - `sram_o` is driven only from `gnt_q`. Other requesters see `ready=0`.
  - When `sram_i.rq_ready_o` = 1: handshake completes; return to IDLE; `last_q` ← `gnt_q`.
  - A requester must hold valid and payload stable until ready. Dropping valid while locked is a protocol violation (simulation assertion); the arbiter stays locked.
- `req_ready_o[k]` = `sram_i.rq_ready_o` & granted(k).
- `sram_o.rq_valid_i` = 0 when nothing is granted. Payload fields are then don't-care but driven from requester 0.
- Read tracking:
  - On each accepted read: push the requester index into the ID FIFO.
  - On `sram_i.rd_valid_o`: pop; `req_rd_valid_o` = onehot(head).
  - `req_rd_data_o` = `sram_i.rd_data_o`.
  - Push and pop in the same cycle: count unchanged.
  - `rd_valid_o` with the FIFO empty: ignored (assertion).
- `busy_o` = `lock_q` | (fifo_count≠0).

## Timing
- Request path: combinational, 0-cycle grant. An uncontended request is accepted in the cycle the SRAM asserts ready.
- Read-return path: combinational from `sram_i.rd_valid_o`; no added latency.
- Only registered outputs/state change on the clock edge.
- Reset values: `gnt_q`=0, `lock_q`=0, `last_q`=`numReq-1` (so requester 0 wins first), FIFO pointers and count = 0.
  - All `req_ready_o`, `req_rd_valid_o`, `sram_o.rq_valid_i` = 0 during reset.
- Reset mid-transaction: the lock and outstanding IDs are dropped; in-flight SRAM reads returning after reset are ignored.
- FIFO pointers are `$clog2(maxOutstanding)` bits and wrap naturally. The count is one bit wider; full when count == `maxOutstanding`.
- Fairness: with all requesters continuously valid and the SRAM always ready, grants rotate 0,1,…,`numReq-1`,0.

## Structure
- Add to `qracc_pkg`:
  - Constant `arbIdBits = $clog2(numReq)`.
  - Typedef `sram_req_t` (`wr`, `addr`, `wr_data`) for the packed requester payload.
- Reuse `to_sram_t`/`from_sram_t` unchanged.
- One sub-module: `qracc_id_fifo`, a synchronous FIFO parameterized by width and depth with full/empty/count outputs. Everything else stays in the top.

## Test plan
- Single requester 1 writes `addr=5`, `data=32'hDEADBEEF`; SRAM ready every cycle -> `sram_o` carries it in the same cycle, `req_ready_o=2'b10`, no lock.
- Both requesters valid for 6 cycles with the SRAM always ready -> grants alternate 0,1,0,1,0,1; no requester is starved.
- SRAM ready held low 3 cycles while requester 0 is locked and requester 1 raises valid -> `sram_o` stays on requester 0; requester 1 is granted the cycle after requester 0's handshake.
- Reads requester0 `addr 1`, requester1 `addr 2`, requester0 `addr 3`; SRAM returns `rd_valid` 2 cycles later in order -> `req_rd_valid_o` = 01, 10, 01 with the matching data.
- Four reads outstanding (FIFO full) and requester 1 requests a read -> `req_ready_o[1]` stays 0 until a `rd_valid` pops; a requester 0 write is still granted meanwhile.
- Assert `rst` while locked with 2 reads outstanding -> next cycle `busy_o=0`, no `req_rd_valid_o` for the late SRAM returns, and requester 0 wins the next contention.
